// File: rtl/fwft_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fwft_fifo_ctrl
//
// Controller for a first-word-fall-through FIFO built around an external
// dual-port RAM with a registered read port (1-cycle latency, output holds
// while not read). The controller owns the write/read pointers, the count
// of words still in RAM and the "word presented" valid bit. It prefetches
// the next word so the head of the FIFO is always visible on rd_data_o
// while empty_o is low.
//
// Capacity is DEPTH+1 words: DEPTH in the RAM array plus the one word held
// in the RAM read register.
//
// Optional build macro:
//   FWFT_FIFO_ERR_EN  - when defined, ovf_o / udf_o are sticky error flags
//                       (write-when-full / read-when-empty) cleared only by
//                       rst_i. When undefined both outputs are tied to 0.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), async active-high reset
//   wr_req_i, wr_data_i  write request and data
//   rd_req_i             pop request; acknowledges the word on rd_data_o
//   rd_data_o            head word (valid while empty_o = 0)
//   empty_o, full_o      status flags (full_o refers to the RAM array)
//   usedw_o              total words held, 0..DEPTH+1
//   ovf_o, udf_o         sticky error flags (see macro above)
//   ram_wr_*             RAM write port: address, data, enable
//   ram_rd_addr_o/_o     RAM read address and enable
//   ram_rd_data_i        RAM registered read data
// ---------------------------------------------------------------------------
module fwft_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_req_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_req_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic [ADDR_WIDTH:0]   usedw_o,
   output logic                  ovf_o,
   output logic                  udf_o,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wr_data_o,
   output logic                  ram_wr_o,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
   output logic                  ram_rd_o,
   input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

   // DEPTH expressed in the count width (1 followed by ADDR_WIDTH zeros).
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] wr_ptr_reg;
   logic [ADDR_WIDTH-1:0] rd_ptr_reg;
   logic [ADDR_WIDTH:0]   mem_cnt_reg;
   logic [ADDR_WIDTH:0]   mem_cnt_next;
   logic                  out_valid_reg;
   logic                  out_valid_next;

   logic full;
   logic wr_acc;
   logic pop;
   logic prefetch;

   assign full   = (mem_cnt_reg == DEPTH_CNT);
   assign wr_acc = wr_req_i & ~full;
   assign pop    = rd_req_i & out_valid_reg;

   // Fetch ahead whenever the RAM has a word and the presentation slot is
   // free now or is being freed by this cycle's pop. The RAM slot is released
   // at once because the word moves into the RAM read register.
   assign prefetch = (mem_cnt_reg != '0) & (~out_valid_reg | pop);

   always_comb begin
      mem_cnt_next = mem_cnt_reg;
      case ({wr_acc, prefetch})
         2'b10:   mem_cnt_next = mem_cnt_reg + 1'b1;
         2'b01:   mem_cnt_next = mem_cnt_reg - 1'b1;
         default: mem_cnt_next = mem_cnt_reg;
      endcase
   end

   always_comb begin
      out_valid_next = out_valid_reg;
      if (prefetch) begin
         out_valid_next = 1'b1;
      end else if (pop) begin
         out_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         mem_cnt_reg   <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (prefetch) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         mem_cnt_reg   <= mem_cnt_next;
         out_valid_reg <= out_valid_next;
      end
   end

   // RAM interface
   assign ram_wr_addr_o = wr_ptr_reg;
   assign ram_wr_data_o = wr_data_i;
   assign ram_wr_o      = wr_acc;
   assign ram_rd_addr_o = rd_ptr_reg;
   assign ram_rd_o      = prefetch;

   // Status
   assign rd_data_o = ram_rd_data_i;
   assign empty_o   = ~out_valid_reg;
   assign full_o    = full;
   assign usedw_o   = mem_cnt_reg + {{ADDR_WIDTH{1'b0}}, out_valid_reg};

`ifdef FWFT_FIFO_ERR_EN
   logic ovf_reg;
   logic udf_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_reg <= 1'b0;
         udf_reg <= 1'b0;
      end else begin
         if (wr_req_i && full) begin
            ovf_reg <= 1'b1;
         end
         if (rd_req_i && !out_valid_reg) begin
            udf_reg <= 1'b1;
         end
      end
   end

   assign ovf_o = ovf_reg;
   assign udf_o = udf_reg;
`else
   assign ovf_o = 1'b0;
   assign udf_o = 1'b0;
`endif

endmodule
